// File: rtl/ser_pkg.sv
// ---------------------------------------------------------------------------
// ser_pkg: shared types and sizing for the bit serializer.
//   SER_W          default data word width
//   cnt_width()    bit-index counter width for a given word width
//   SER_CNT_W      counter width for the default word width
//   ser_state_e    FSM state encoding (PARITY only with SER_PARITY_EN)
// ---------------------------------------------------------------------------
package ser_pkg;

    localparam int unsigned SER_W = 8;

    // Counter must index 0..w-1; never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned w);
        return (w < 2) ? 1 : $clog2(w);
    endfunction

    localparam int unsigned SER_CNT_W = cnt_width(SER_W);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1
`ifdef SER_PARITY_EN
        ,
        PARITY = 2'd2
`endif
    } ser_state_e;

endpackage

// File: rtl/ser_hold_buf.sv
// ---------------------------------------------------------------------------
// ser_hold_buf: single-entry hold register with valid flag.
//   clk, rst   clock, synchronous active-high reset
//   load       capture din and mark full (wins over unload)
//   unload     release the held word
//   din        word to capture
//   dout       held word
//   full       hold register occupied
// ---------------------------------------------------------------------------
module ser_hold_buf
    import ser_pkg::*;
#(
    parameter int unsigned W = SER_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         unload,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic         full
);

    logic [W-1:0] data_q;
    logic         full_q;

    // A load in the same cycle as an unload refills the entry without loss.
    always_ff @(posedge clk) begin
        if (rst) begin
            data_q <= '0;
            full_q <= 1'b0;
        end else if (load) begin
            data_q <= din;
            full_q <= 1'b1;
        end else if (unload) begin
            full_q <= 1'b0;
        end
    end

    assign dout = data_q;
    assign full = full_q;

endmodule

// File: rtl/bit_serializer.sv
// ---------------------------------------------------------------------------
// bit_serializer: parallel word to serial bit stream, hold + shift buffering.
//   clk, rst        clock, synchronous active-high reset
//   s_valid/s_ready upstream handshake; s_data sampled on s_valid && s_ready
//   dout            serial bit (IDLE_LEVEL when dout_valid is low)
//   dout_valid      dout carries a real bit
//   busy            hold register full or a word in flight
//   words_sent      fully transmitted words, modulo 256
// Optional feature: define SER_PARITY_EN to append one even-parity bit
// after each word's data bits.
// ---------------------------------------------------------------------------
module bit_serializer
    import ser_pkg::*;
#(
    parameter int unsigned W          = SER_W,
    parameter bit          LSB_FIRST  = 1'b0,
    parameter bit          IDLE_LEVEL = 1'b0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         s_valid,
    output logic         s_ready,
    input  logic [W-1:0] s_data,
    output logic         dout,
    output logic         dout_valid,
    output logic         busy,
    output logic [7:0]   words_sent
);

    localparam int unsigned CNT_W = cnt_width(W);

    ser_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [W-1:0]     sreg_q, sreg_d;
    logic [7:0]       words_q, words_d;
    logic             hold_full;
    logic [W-1:0]     hold_data;
    logic             load;
    logic             unload;
`ifdef SER_PARITY_EN
    logic             par_q, par_d;
`endif

    // Acceptance depends only on registered hold state.
    assign s_ready = !hold_full;
    assign load    = s_valid && !hold_full;

    ser_hold_buf #(.W(W)) u_hold (
        .clk    (clk),
        .rst    (rst),
        .load   (load),
        .unload (unload),
        .din    (s_data),
        .dout   (hold_data),
        .full   (hold_full)
    );

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            sreg_q  <= '0;
            words_q <= '0;
`ifdef SER_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sreg_q  <= sreg_d;
            words_q <= words_d;
`ifdef SER_PARITY_EN
            par_q   <= par_d;
`endif
        end
    end

    // Next-state: hold->shift transfer, bit stepping, end-of-word reload.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sreg_d  = sreg_q;
        words_d = words_q;
        unload  = 1'b0;
`ifdef SER_PARITY_EN
        par_d   = par_q;
`endif
        case (state_q)
            IDLE: begin
                if (hold_full) begin
                    unload  = 1'b1;
                    sreg_d  = hold_data;
                    cnt_d   = '0;
`ifdef SER_PARITY_EN
                    par_d   = ^hold_data;
`endif
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                sreg_d = LSB_FIRST ? {1'b0, sreg_q[W-1:1]} : {sreg_q[W-2:0], 1'b0};
                cnt_d  = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(W - 1)) begin
                    cnt_d = '0;
`ifdef SER_PARITY_EN
                    state_d = PARITY;
`else
                    words_d = words_q + 8'd1;
                    // Reload straight from hold for zero-gap back-to-back words.
                    if (hold_full) begin
                        unload  = 1'b1;
                        sreg_d  = hold_data;
                        state_d = SHIFT;
                    end else begin
                        state_d = IDLE;
                    end
`endif
                end
            end
`ifdef SER_PARITY_EN
            PARITY: begin
                words_d = words_q + 8'd1;
                if (hold_full) begin
                    unload  = 1'b1;
                    sreg_d  = hold_data;
                    cnt_d   = '0;
                    par_d   = ^hold_data;
                    state_d = SHIFT;
                end else begin
                    state_d = IDLE;
                end
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    // Serial output is decoded from registered state only.
    always_comb begin
        dout = IDLE_LEVEL;
        case (state_q)
            SHIFT:  dout = LSB_FIRST ? sreg_q[0] : sreg_q[W-1];
`ifdef SER_PARITY_EN
            PARITY: dout = par_q;
`endif
            default: dout = IDLE_LEVEL;
        endcase
    end

    assign dout_valid = (state_q != IDLE);
    assign busy       = hold_full || (state_q != IDLE);
    assign words_sent = words_q;

endmodule

// File: tb/tb_bit_serializer.sv
// ---------------------------------------------------------------------------
// tb_bit_serializer: directed self-checking bench for bit_serializer.
// Two instances share stimulus: u_msb (MSB first) and u_lsb (LSB first).
// ---------------------------------------------------------------------------
module tb_bit_serializer;

    localparam int unsigned W = 8;
`ifdef SER_PARITY_EN
    localparam int unsigned NB = W + 1;
`else
    localparam int unsigned NB = W;
`endif

    logic         clk;
    logic         rst;
    logic         s_valid;
    logic [W-1:0] s_data;

    logic         s_ready_m, dout_m, dout_valid_m, busy_m;
    logic [7:0]   words_m;
    logic         s_ready_l, dout_l, dout_valid_l, busy_l;
    logic [7:0]   words_l;

    int n_checks = 0;
    int n_pass   = 0;

    bit_serializer #(.W(W), .LSB_FIRST(1'b0), .IDLE_LEVEL(1'b0)) u_msb (
        .clk        (clk),
        .rst        (rst),
        .s_valid    (s_valid),
        .s_ready    (s_ready_m),
        .s_data     (s_data),
        .dout       (dout_m),
        .dout_valid (dout_valid_m),
        .busy       (busy_m),
        .words_sent (words_m)
    );

    bit_serializer #(.W(W), .LSB_FIRST(1'b1), .IDLE_LEVEL(1'b0)) u_lsb (
        .clk        (clk),
        .rst        (rst),
        .s_valid    (s_valid),
        .s_ready    (s_ready_l),
        .s_data     (s_data),
        .dout       (dout_l),
        .dout_valid (dout_valid_l),
        .busy       (busy_l),
        .words_sent (words_l)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: observed no finish, expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    endtask

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    // Caller sits at the negedge carrying bit 0; returns at the negedge after the word.
    task automatic stream(input logic [W-1:0] word, input int ridx, input logic rexp);
        for (int i = 0; i < int'(W); i++) begin
            chk1("msb_valid", dout_valid_m, 1'b1);
            chk1("msb_bit",   dout_m,       word[W-1-i]);
            chk1("lsb_valid", dout_valid_l, 1'b1);
            chk1("lsb_bit",   dout_l,       word[i]);
            if (i == ridx) chk1("ready_in_word", s_ready_m, rexp);
            @(negedge clk);
        end
`ifdef SER_PARITY_EN
        chk1("msb_par_valid", dout_valid_m, 1'b1);
        chk1("msb_par_bit",   dout_m,       ^word);
        chk1("lsb_par_bit",   dout_l,       ^word);
        @(negedge clk);
`endif
    endtask

    // Single isolated word; a second word offered while not ready must be dropped.
    task automatic send_one(input logic [W-1:0] word, input int exp_count);
        s_valid = 1'b1;
        s_data  = word;
        @(negedge clk);
        chk1("latency_gap_valid", dout_valid_m, 1'b0);
        chk1("hold_full_not_ready", s_ready_m, 1'b0);
        s_data = ~word;
        @(negedge clk);
        s_valid = 1'b0;
        stream(word, 0, 1'b1);
        chk1("after_valid", dout_valid_m, 1'b0);
        chk1("after_idle_level", dout_m, 1'b0);
        chk1("after_busy", busy_m, 1'b0);
        chk32("after_words_msb", 32'(words_m), 32'(exp_count));
        chk32("after_words_lsb", 32'(words_l), 32'(exp_count));
    endtask

    initial begin
        rst     = 1'b1;
        s_valid = 1'b0;
        s_data  = '0;
        repeat (3) @(negedge clk);

        // Reset values
        chk1("rst_s_ready", s_ready_m, 1'b1);
        chk1("rst_dout", dout_m, 1'b0);
        chk1("rst_dout_valid", dout_valid_m, 1'b0);
        chk1("rst_busy", busy_m, 1'b0);
        chk32("rst_words", 32'(words_m), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // 0xA5 -> 1,0,1,0,0,1,0,1 MSB first; 0x01 -> 1 first on the LSB-first unit
        send_one(8'hA5, 1);
        send_one(8'h01, 2);

        // Back-to-back 0x0B x3 with s_valid held: contiguous stream
        fork
            begin
                automatic int acc = 0;
                automatic int g   = 0;
                s_valid = 1'b1;
                s_data  = 8'h0B;
                while (acc < 3 && g < 100) begin
                    if (s_ready_m) acc++;
                    @(negedge clk);
                    g++;
                end
                s_valid = 1'b0;
            end
            begin
                automatic int k = 0;
                while (!dout_valid_m && k < 10) begin
                    @(negedge clk);
                    k++;
                end
                chk1("b2b_start", dout_valid_m, 1'b1);
                stream(8'h0B, 1, 1'b0);
                stream(8'h0B, 0, 1'b1);
                stream(8'h0B, 1, 1'b1);
            end
        join
        chk1("b2b_end_valid", dout_valid_m, 1'b0);
        chk32("b2b_words", 32'(words_m), 32'd5);

        // Parity vectors (plain words when parity is off): 0x07 parity 1, 0x03 parity 0
        send_one(8'h07, 6);
        send_one(8'h03, 7);

        // Reset after third bit of 0xFF with 0x55 held
        s_valid = 1'b1;
        s_data  = 8'hFF;
        @(negedge clk);
        s_valid = 1'b0;
        @(negedge clk);
        s_valid = 1'b1;
        s_data  = 8'h55;
        chk1("rst_mid_bit0", dout_m, 1'b1);
        @(negedge clk);
        s_valid = 1'b0;
        chk1("rst_mid_bit1", dout_m, 1'b1);
        @(negedge clk);
        chk1("rst_mid_bit2", dout_m, 1'b1);
        chk1("rst_mid_hold_full", s_ready_m, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk1("rst_mid_valid", dout_valid_m, 1'b0);
        chk1("rst_mid_busy", busy_m, 1'b0);
        chk1("rst_mid_ready", s_ready_m, 1'b1);
        chk32("rst_mid_words", 32'(words_m), 32'd0);
        begin
            automatic logic seen = 1'b0;
            repeat (2 * NB + 4) begin
                @(negedge clk);
                seen = seen | dout_valid_m | dout_valid_l;
            end
            chk1("rst_mid_no_bits", seen, 1'b0);
        end

        // 257 back-to-back words: counter wraps to 1
        begin
            automatic int acc  = 0;
            automatic int cyc  = 0;
            automatic int vcnt = 0;
            s_valid = 1'b1;
            s_data  = 8'h5A;
            while (cyc < 4000) begin
                if (dout_valid_m) vcnt++;
                if (acc == 257 && !busy_m) break;
                if (s_valid && s_ready_m) acc++;
                @(negedge clk);
                cyc++;
                if (acc == 257) s_valid = 1'b0;
            end
            s_valid = 1'b0;
            chk1("wrap_done_in_time", (cyc < 4000) ? 1'b1 : 1'b0, 1'b1);
            chk32("wrap_valid_cycles", 32'(vcnt), 32'(257 * NB));
            chk32("wrap_words_msb", 32'(words_m), 32'd1);
            chk32("wrap_words_lsb", 32'(words_l), 32'd1);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
